glitch_filt_ctrl: RTL and testbench

Multi-channel inertial-delay controller for single-bit event lines that must not propagate short pulses into downstream sequential logic. Each channel forwards a level change only after the input has held the new level for DELAY consecutive clocks; shorter pulses are rejected. Rejected pulses are reported one at a time through a round-robin-arbitrated valid/ready port. The block sits between asynchronous-ish control lines (already synchronized) and the edge-sensitive consumers that follow them.

---
 rtl/glitch_filt_pkg.sv | 25 ++
 rtl/glitch_filt_chan.sv | 89 ++++++++
 rtl/glitch_filt_ctrl.sv | 123 ++++++++++++
 tb/tb_glitch_filt_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_filt_pkg.sv
// glitch_filt_pkg: shared types for the glitch filter controller.
//   state_t      - per-channel filter state (STABLE / PENDING)
//   rpt_t        - glitch report payload (channel, rejected level, overrun)
//   chan_idx_w() - width of a channel index, at least 1 bit
// Optional feature macro used by the slice: GLITCH_FILT_STATS_EN.
package glitch_filt_pkg;

  localparam int unsigned MAX_CHAN_W = 4;  // CHANNELS is limited to 1..16

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  typedef struct packed {
    logic [MAX_CHAN_W-1:0] chan;
    logic                  level;
    logic                  ovr;
  } rpt_t;

  function automatic int unsigned chan_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/glitch_filt_chan.sv
// glitch_filt_chan: one inertial-delay channel.
//   Ports: clk, reset (sync, active-high), enable, din (raw level),
//          clr (report grant: clears flag/ovr), dout (filtered level),
//          pending (unconfirmed change in progress), flag/flag_level/flag_ovr
//          (pending glitch report), reject (pulse rejected this cycle).
// dout follows din only after DELAY consecutive sampled edges at the new level.
module glitch_filt_chan
  import glitch_filt_pkg::*;
#(
  parameter int unsigned DELAY = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic din,
  input  logic clr,
  output logic dout,
  output logic pending,
  output logic flag,
  output logic flag_level,
  output logic flag_ovr,
  output logic reject
);

  localparam int unsigned CW = $clog2(DELAY + 1);

  state_t        state;
  logic [CW-1:0] cnt;

  assign pending = (state == PENDING);
  assign reject  = enable && (state == PENDING) && (din == dout);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STABLE;
      cnt        <= '0;
      dout       <= 1'b0;
      flag       <= 1'b0;
      flag_level <= 1'b0;
      flag_ovr   <= 1'b0;
    end else begin
      if (!enable) begin
        state <= STABLE;
        cnt   <= '0;
      end else begin
        case (state)
          STABLE: begin
            if (din != dout) begin
              if (DELAY == 1) begin
                dout <= din;
              end else begin
                state <= PENDING;
                cnt   <= CW'(1);
              end
            end
          end
          PENDING: begin
            if (din == dout) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == CW'(DELAY - 1)) begin
              dout  <= din;
              state <= STABLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end

      // A new rejection wins over a same-edge grant; it only counts as an
      // overrun if the earlier glitch is still waiting (not granted now).
      if (reject) begin
        flag       <= 1'b1;
        flag_level <= !dout;
        flag_ovr   <= flag && !clr;
      end else if (clr) begin
        flag     <= 1'b0;
        flag_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/glitch_filt_ctrl.sv
// glitch_filt_ctrl: multi-channel glitch filter with round-robin report port.
//   Ports: clk, reset (sync, active-high), enable, din[CHANNELS],
//          dout[CHANNELS], pending[CHANNELS],
//          rpt_valid/rpt_ready/rpt_chan/rpt_level/rpt_ovr (report handshake),
//          glitch_count[CNT_W] (only when GLITCH_FILT_STATS_EN is defined).
// Define GLITCH_FILT_STATS_EN to add the saturating rejected-pulse counter.
module glitch_filt_ctrl
  import glitch_filt_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DELAY    = 5,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [CHANNELS-1:0]                 din,
  output logic [CHANNELS-1:0]                 dout,
  output logic [CHANNELS-1:0]                 pending,
  output logic                                rpt_valid,
  input  logic                                rpt_ready,
  output logic [chan_idx_w(CHANNELS)-1:0]     rpt_chan,
  output logic                                rpt_level,
  output logic                                rpt_ovr
`ifdef GLITCH_FILT_STATS_EN
  ,
  output logic [CNT_W-1:0]                    glitch_count
`endif
);

  localparam int unsigned CW = chan_idx_w(CHANNELS);

  logic [CHANNELS-1:0] flag, flag_level, flag_ovr, reject, clr;
  logic [CW-1:0]       ptr, win;
  logic                any, load;
  int unsigned         idx;
  rpt_t                rpt_q, winner;
  logic                unused_chan_bits;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    glitch_filt_chan #(.DELAY(DELAY)) u_chan (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .din        (din[i]),
      .clr        (clr[i]),
      .dout       (dout[i]),
      .pending    (pending[i]),
      .flag       (flag[i]),
      .flag_level (flag_level[i]),
      .flag_ovr   (flag_ovr[i]),
      .reject     (reject[i])
    );
  end

  // Round-robin: ptr holds the last granted channel, so the search begins
  // one past it and wraps, visiting the last winner last.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      idx = (32'(ptr) + k) % CHANNELS;
      if (!any && flag[idx]) begin
        any = 1'b1;
        win = CW'(idx);
      end
    end
  end

  assign load = !rpt_valid || rpt_ready;
  assign clr  = (load && any) ? (CHANNELS'(1) << win) : '0;

  always_comb begin
    winner       = '0;
    winner.chan  = MAX_CHAN_W'(win);
    winner.level = flag_level[win];
    winner.ovr   = flag_ovr[win];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_valid <= 1'b0;
      rpt_q     <= '0;
      ptr       <= '0;
    end else if (load) begin
      rpt_valid <= any;
      if (any) begin
        rpt_q <= winner;
        ptr   <= win;
      end
    end
  end

  assign rpt_chan         = rpt_q.chan[CW-1:0];
  assign rpt_level        = rpt_q.level;
  assign rpt_ovr          = rpt_q.ovr;
  assign unused_chan_bits = ^rpt_q.chan;

`ifdef GLITCH_FILT_STATS_EN
  logic [CNT_W+4:0] stat_sum;

  always_comb begin
    stat_sum = {5'b0, glitch_count};
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      stat_sum = stat_sum + (CNT_W + 5)'(reject[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_count <= '0;
    end else if (stat_sum[CNT_W+4:CNT_W] != '0) begin
      glitch_count <= '1;
    end else begin
      glitch_count <= stat_sum[CNT_W-1:0];
    end
  end
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_glitch_filt_ctrl.sv
// tb_glitch_filt_ctrl: directed bench for glitch_filt_ctrl (CHANNELS=4,
// DELAY=5, CNT_W=8). Expected reports are queued when a glitch is driven and
// compared when the report handshake happens. Build with
// GLITCH_FILT_STATS_EN defined to include the glitch_count checks.
module tb_glitch_filt_ctrl;

  localparam int unsigned CH = 4;
  localparam int unsigned DL = 5;
  localparam int unsigned CNTW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, rpt_ready;
  logic [CH-1:0] din, dout, pending;
  logic          rpt_valid, rpt_level, rpt_ovr;
  logic [1:0]    rpt_chan;
`ifdef GLITCH_FILT_STATS_EN
  logic [CNTW-1:0] glitch_count;
`endif

  always #5 clk = ~clk;

  glitch_filt_ctrl #(.CHANNELS(CH), .DELAY(DL), .CNT_W(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .din       (din),
    .dout      (dout),
    .pending   (pending),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_chan  (rpt_chan),
    .rpt_level (rpt_level),
    .rpt_ovr   (rpt_ovr)
`ifdef GLITCH_FILT_STATS_EN
    ,
    .glitch_count (glitch_count)
`endif
  );

  typedef struct {
    int unsigned chan;
    logic        level;
    logic        ovr;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_rpt(input int unsigned c, input logic lvl, input logic ovr);
    exp_t e;
    e.chan  = c;
    e.level = lvl;
    e.ovr   = ovr;
    q.push_back(e);
  endtask

  // Report monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rpt_valid && rpt_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_report observed chan=%0d level=%0b expected none",
               rpt_chan, rpt_level);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rpt_chan", 32'(rpt_chan), e.chan);
        chk("rpt_level", 32'(rpt_level), 32'(e.level));
        chk("rpt_ovr", 32'(rpt_ovr), 32'(e.ovr));
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; rpt_ready = 1'b1; din = '0;
    step(3);
    chk("reset_dout", 32'(dout), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_rpt_valid", 32'(rpt_valid), 0);
    chk("reset_rpt_fields", {29'b0, rpt_chan, rpt_level}, 0);
    chk("reset_rpt_ovr", 32'(rpt_ovr), 0);
    reset = 1'b0;
    step(1);

    // 3-clock pulse on ch0 is rejected
    din[0] = 1'b1;
    step(1);
    chk("t1_pending", 32'(pending[0]), 1);
    step(2);
    din[0] = 1'b0;
    expect_rpt(0, 1'b1, 1'b0);
    step(1);
    chk("t1_dout", 32'(dout[0]), 0);
    chk("t1_pending_clr", 32'(pending[0]), 0);
    chk("t1_rpt_not_yet", 32'(rpt_valid), 0);
    step(1);
    chk("t1_rpt_valid", 32'(rpt_valid), 1);
    step(3);
    chk("t1_rpt_drained", 32'(rpt_valid), 0);
`ifdef GLITCH_FILT_STATS_EN
    chk("t1_glitch_count", 32'(glitch_count), 1);
`endif

    // held level is accepted on the DELAY-th sampled edge
    din[0] = 1'b1;
    step(DL - 1);
    chk("t2_dout_early", 32'(dout[0]), 0);
    step(1);
    chk("t2_dout_rise", 32'(dout[0]), 1);
    chk("t2_pending", 32'(pending[0]), 0);
    step(5);
    din[0] = 1'b0;
    step(DL);
    chk("t2_dout_fall", 32'(dout[0]), 0);
    chk("t2_no_report", 32'(rpt_valid), 0);

    // simultaneous glitches on ch1/ch3, round-robin order
    for (int r = 0; r < 2; r++) begin
      din[1] = 1'b1; din[3] = 1'b1;
      step(2);
      din[1] = 1'b0; din[3] = 1'b0;
      expect_rpt(1, 1'b1, 1'b0);
      expect_rpt(3, 1'b1, 1'b0);
      step(1);
      step(1);
      chk("t4_first_chan", 32'(rpt_chan), 1);
      chk("t4_first_valid", 32'(rpt_valid), 1);
      step(1);
      chk("t4_second_chan", 32'(rpt_chan), 3);
      chk("t4_second_valid", 32'(rpt_valid), 1);
      step(2);
    end

    // longest rejectable pulse: DELAY-1 sampled edges
    din[3] = 1'b1;
    step(DL - 1);
    din[3] = 1'b0;
    expect_rpt(3, 1'b1, 1'b0);
    step(1);
    chk("tb_dout3", 32'(dout[3]), 0);
    step(3);

    // back-pressure: three pulses on ch2 while rpt_ready is low
    rpt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      din[2] = 1'b1;
      step(2);
      din[2] = 1'b0;
      step(2);
    end
    expect_rpt(2, 1'b1, 1'b0);
    expect_rpt(2, 1'b1, 1'b1);
    chk("t3_hold_valid", 32'(rpt_valid), 1);
    chk("t3_hold_chan", 32'(rpt_chan), 2);
    chk("t3_hold_ovr", 32'(rpt_ovr), 0);
    rpt_ready = 1'b1;
    step(1);
    chk("t3_second_ovr", 32'(rpt_ovr), 1);
    chk("t3_second_valid", 32'(rpt_valid), 1);
    step(2);
    chk("t3_drained", 32'(rpt_valid), 0);
`ifdef GLITCH_FILT_STATS_EN
    chk("t3_glitch_count", 32'(glitch_count), 9);
`endif

    // reset in the middle of a pending change
    din[0] = 1'b1;
    step(3);
    chk("t5_pending_before", 32'(pending[0]), 1);
    reset = 1'b1;
    din[0] = 1'b0;
    step(1);
    chk("t5_pending", 32'(pending), 0);
    chk("t5_dout", 32'(dout), 0);
    chk("t5_rpt_valid", 32'(rpt_valid), 0);
`ifdef GLITCH_FILT_STATS_EN
    chk("t5_glitch_count", 32'(glitch_count), 0);
`endif
    reset = 1'b0;
    step(6);
    chk("t5_dout_after", 32'(dout), 0);
    chk("t5_no_report", 32'(rpt_valid), 0);

    // enable low cancels a pending change; re-enable restarts full DELAY
    din[0] = 1'b1;
    step(2);
    chk("t6_pending", 32'(pending[0]), 1);
    enable = 1'b0;
    step(1);
    chk("t6_pending_cancel", 32'(pending[0]), 0);
    step(3);
    chk("t6_dout_frozen", 32'(dout[0]), 0);
    chk("t6_no_report", 32'(rpt_valid), 0);
    enable = 1'b1;
    step(DL - 1);
    chk("t6_dout_early", 32'(dout[0]), 0);
    chk("t6_pending_again", 32'(pending[0]), 1);
    step(1);
    chk("t6_dout_rise", 32'(dout[0]), 1);
    din[0] = 1'b0;
    step(DL + 1);

    for (int i = 0; i < 20 && q.size() != 0; i++) step(1);
    chk("scoreboard_empty", 32'(q.size()), 0);
`ifdef GLITCH_FILT_STATS_EN
    chk("final_glitch_count", 32'(glitch_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
